// File: rtl/instruction_memory.sv
// Word-addressed instruction store with combinational fetch, byte-enabled load port
// and a built-in boot program restored by the asynchronous reset.
module instruction_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  output logic [DATA_WIDTH-1:0]   instruction,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    wr_lock,
  output logic                    wr_ack,
  output logic [7:0]              wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;
  logic                  accept;

  function automatic logic [DATA_WIDTH-1:0] boot(input int idx);
    logic [31:0] w;
    unique case (idx)
      0:       w = 32'h0010_0093;
      1:       w = 32'h0020_0113;
      2:       w = 32'h0020_81B3;
      3:       w = 32'h0000_006F;
      default: w = 32'h0000_0013;
    endcase
    return DATA_WIDTH'(w);
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign lane_mask[8*g +: 8] = {8{wr_be[g]}};
  end

  assign accept      = wr_en & ~wr_lock;
  assign instruction = mem[address];

  // Disabled lanes keep the current word; no bypass of wr_data to the fetch port.
  assign merged = (mem[wr_addr] & ~lane_mask)
                | (wr_data & lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem[j[ADDR_WIDTH-1:0]] <= boot(j);
      end
    end else if (accept) begin
      mem[wr_addr] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack   <= 1'b0;
      wr_count <= 8'd0;
    end else begin
      wr_ack <= accept;
      if (accept && wr_count != 8'hFF) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reference model plus
// per-cycle compare and literal spot checks.
module tb_instruction_memory;

  logic        clk = 1'b0;
  logic        clk_on = 1'b0;
  logic        rst_n;
  logic [1:0]  address = 2'd0;
  logic [31:0] instruction;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_be = 4'd0;
  logic        wr_lock = 1'b0;
  logic        wr_ack;
  logic [7:0]  wr_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_mem [4];
  logic        m_ack;
  int          m_cnt;

  instruction_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .address(address),
    .instruction(instruction), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_lock(wr_lock), .wr_ack(wr_ack), .wr_count(wr_count)
  );

  always #5 clk = clk_on ? ~clk : clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: boot image, byte merge, saturating count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mem[0] <= 32'h00100093;
      m_mem[1] <= 32'h00200113;
      m_mem[2] <= 32'h002081B3;
      m_mem[3] <= 32'h0000006F;
      m_ack    <= 1'b0;
      m_cnt    <= 0;
    end else begin
      m_ack <= wr_en && !wr_lock;
      if (wr_en && !wr_lock) begin
        logic [31:0] w;
        w = m_mem[wr_addr];
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
        m_mem[wr_addr] <= w;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_instr", instruction, m_mem[address]);
      chk("model_ack", {31'd0, wr_ack}, {31'd0, m_ack});
      chk("model_count", {24'd0, wr_count}, m_cnt[31:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] boot [4];
    boot[0] = 32'h00100093;
    boot[1] = 32'h00200113;
    boot[2] = 32'h002081B3;
    boot[3] = 32'h0000006F;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_ack", {31'd0, wr_ack}, 32'd0);
    chk("rst_count", {24'd0, wr_count}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = i[1:0];
      #1 chk("boot_sweep", instruction, boot[i]);
      #9;
    end

    clk_on = 1'b1;
    chk_en = 1'b1;
    step();

    // Full write; old word visible until the edge.
    address = 2'd1;
    wr_en = 1'b1; wr_addr = 2'd1;
    wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    #1 chk("rdw_old", instruction, 32'h00200113);
    step();
    wr_en = 1'b0;
    chk("full_wr", instruction, 32'hDEADBEEF);
    chk("full_ack", {31'd0, wr_ack}, 32'd1);
    chk("full_cnt", {24'd0, wr_count}, 32'd1);
    step();
    chk("ack_drop", {31'd0, wr_ack}, 32'd0);

    // Partial write, lanes 0 and 2.
    address = 2'd2;
    wr_en = 1'b1; wr_addr = 2'd2;
    wr_data = 32'hAABBCCDD; wr_be = 4'b0101;
    step();
    wr_en = 1'b0;
    chk("part_wr", instruction, 32'h00BB81DD);
    chk("part_cnt", {24'd0, wr_count}, 32'd2);

    // Locked write is ignored.
    address = 2'd0;
    wr_en = 1'b1; wr_lock = 1'b1; wr_addr = 2'd0;
    wr_data = 32'h12345678; wr_be = 4'hF;
    step();
    chk("lock_data", instruction, 32'h00100093);
    chk("lock_ack", {31'd0, wr_ack}, 32'd0);
    chk("lock_cnt", {24'd0, wr_count}, 32'd2);
    wr_lock = 1'b0;

    // Zero byte enables: counted, data unchanged.
    wr_be = 4'h0;
    step();
    wr_en = 1'b0;
    chk("be0_data", instruction, 32'h00100093);
    chk("be0_ack", {31'd0, wr_ack}, 32'd1);
    chk("be0_cnt", {24'd0, wr_count}, 32'd3);

    // Overwrite word 3 then reset between edges.
    address = 2'd3;
    wr_en = 1'b1; wr_addr = 2'd3;
    wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    step();
    wr_en = 1'b0;
    chk("w3_wr", instruction, 32'hFFFFFFFF);
    chk("w3_cnt", {24'd0, wr_count}, 32'd4);
    #1 rst_n = 1'b0;
    wr_en = 1'b1; wr_data = 32'h0;
    #1;
    chk("arst_data", instruction, 32'h0000006F);
    chk("arst_cnt", {24'd0, wr_count}, 32'd0);
    chk("arst_ack", {31'd0, wr_ack}, 32'd0);
    step();
    chk("rst_dom_data", instruction, 32'h0000006F);
    chk("rst_dom_cnt", {24'd0, wr_count}, 32'd0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    step();

    // Saturation with continuous ack.
    wr_en = 1'b1; wr_be = 4'hF;
    for (int i = 0; i < 300; i++) begin
      wr_addr = i[1:0];
      wr_data = 32'hC0DE0000 + i;
      step();
      chk("b2b_ack", {31'd0, wr_ack}, 32'd1);
    end
    wr_en = 1'b0;
    chk("sat_cnt", {24'd0, wr_count}, 32'd255);
    address = 2'd3;
    #1 chk("sat_last", instruction, 32'hC0DE0000 + 299);
    step();
    chk("sat_ack_drop", {31'd0, wr_ack}, 32'd0);
    chk("sat_hold", {24'd0, wr_count}, 32'd255);
    step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Word-addressed instruction store for the RISC-V core; the fetch stage drives a word index and receives the 32-bit instruction combinationally, with no clock latency.
- A synchronous load port lets the host or bootloader overwrite words with per-byte enables.
- The asynchronous active-low reset restores a built-in boot program, so the core runs a known sequence straight out of reset.

Parameters:
- DATA_WIDTH, 32, instruction/word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 2, word-index width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  single clock; all writes are sampled on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  word index for fetch (word index, not a byte address).
- instruction  output  DATA_WIDTH  word stored at address; combinational.
- wr_en  input  1  load-port write strobe.
- wr_addr  input  ADDR_WIDTH  load-port word index.
- wr_data  input  DATA_WIDTH  load-port write data.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i selects byte lane [8i+7:8i].
- wr_lock  input  1  when 1, all writes are ignored.
- wr_ack  output  1  one-cycle pulse on the cycle after an accepted write.
- wr_count  output  8  count of accepted writes since reset; saturates at 255.

Behaviour:
- Read path:
  - instruction = mem[address], purely combinational; it changes within the same delta time as address, with no clock needed.
  - Every address in 0..2**ADDR_WIDTH-1 is valid; there is no out-of-range case.
- Reset (rst_n = 0), asynchronous and immediate:
  - mem[0] = 32'h00100093 (addi x1,x0,1)
  - mem[1] = 32'h00200113 (addi x2,x0,2)
  - mem[2] = 32'h002081B3 (add x3,x1,x2)
  - mem[3] = 32'h0000006F (jal x0,0)
  - all words with index >= 4 = 32'h00000013 (nop).
  - For DATA_WIDTH != 32, the boot words are zero-extended or truncated to DATA_WIDTH.
  - wr_ack = 0 and wr_count = 0.
- Reset dominance:
  - While rst_n is low, writes are ignored and contents stay at their boot values.
  - Reset asserted mid-operation overrides any write on the same edge.
- Write acceptance: on a rising clk edge with rst_n = 1, wr_en = 1 and wr_lock = 0, the write is accepted.
  - Each byte lane with wr_be[i] = 1 takes wr_data's lane i; lanes with wr_be[i] = 0 keep their old value.
  - A write with wr_be all zero still counts as accepted: it pulses wr_ack and increments wr_count, but leaves data unchanged.
- Read during write: if address == wr_addr, instruction shows the old word until the write edge, then the new word combinationally after it. There is no bypass of wr_data.
- wr_ack:
  - Registered; equals 1 for exactly the cycle following an accepted write.
  - Back-to-back accepted writes hold it high continuously.
- wr_count: increments by 1 per accepted write and saturates at 8'hFF (no wrap).
- Rejected writes (wr_lock = 1 or wr_en = 0): no state change and no ack.
- The fetch port has no handshake; the fetch stage may change address every cycle or asynchronously.

Test Plan:
- Reset, then sweep address 0,1,2,3 at 10 ns steps with no clock edges -> instruction = 00100093, 00200113, 002081B3, 0000006F, each update immediate.
- Full write wr_addr=1, wr_data=DEADBEEF, wr_be=4'hF -> after the edge mem[1] reads DEADBEEF, wr_ack pulses for 1 cycle, wr_count = 1.
- Partial write wr_addr=2, wr_data=AABBCCDD, wr_be=4'b0101 -> mem[2] = 00BB81DD.
- wr_lock=1 with wr_en=1, wr_addr=0, data=12345678 -> mem[0] stays 00100093, wr_ack stays 0, wr_count unchanged.
- Write mem[3]=FFFFFFFF, then pulse rst_n low between clock edges -> instruction at address 3 returns to 0000006F immediately, wr_count = 0.
- 300 consecutive accepted writes -> wr_count saturates at 255 and wr_ack stays high throughout.
